// File: rtl/lab5_pkg.sv
// lab5_pkg: shared types for the button front end.
// Holds the press/release FSM state encoding.
package lab5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one async input.
// Ports: clk, rst (async active-low), d (async in), q (synced).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: debounced one-shot pulse per button press.
// Ports: clk, rst (async low), btn_in, x, btn_level, fsm_state.
module btn_pulse_gen
  import lab5_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       x,
  output logic       btn_level,
  output logic [1:0] fsm_state
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  state_t           st_q;
  state_t           st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             x_d;
  logic             lvl_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      x         <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      x         <= x_d;
      btn_level <= lvl_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (btn_s) begin
          st_d  = ST_PRESS_WAIT;
          cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d  = ST_PRESSED;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          st_d  = ST_RELEASE_WAIT;
          cnt_d = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          st_d  = ST_PRESSED;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that the
  // registered copies line up with the state register.
  always_comb begin
    x_d   = 1'b0;
    lvl_d = 1'b0;
    unique case (1'b1)
      (st_d == ST_PRESSED): begin
        x_d   = (st_q == ST_PRESS_WAIT);
        lvl_d = 1'b1;
      end
      (st_d == ST_RELEASE_WAIT): begin
        lvl_d = 1'b1;
      end
      default: begin
        x_d   = 1'b0;
        lvl_d = 1'b0;
      end
    endcase
  end

  assign fsm_state = st_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed bench for btn_pulse_gen.
// D=4, 10 ns clock, outputs sampled 1 ns after rising edges.
module tb_btn_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_in = 1'b0;
  logic       x;
  logic       btn_level;
  logic [1:0] fsm_state;

  int nvec   = 0;
  int nfail  = 0;
  int npulse = 0;
  int p0     = 0;
  logic [1:0] ctr = 2'b00;

  int cp_st [8]  = '{0, 0, 1, 1, 1, 1, 2, 2};
  int cp_x  [8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  int rl_st [7]  = '{2, 2, 3, 3, 3, 3, 0};
  int gl_st [6]  = '{0, 0, 1, 1, 0, 0};
  int rb_st [12] = '{2, 2, 3, 3, 2, 2, 2, 3, 3, 3, 3, 0};
  int ctr_e [4]  = '{1, 2, 3, 0};

  always #5 clk = ~clk;

  btn_pulse_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .x         (x),
    .btn_level (btn_level),
    .fsm_state (fsm_state)
  );

  // Pulse counter plus a stand-in for the 2-bit state counter.
  always @(negedge clk) begin
    if (x === 1'b1) begin
      npulse++;
      ctr <= ctr + 2'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int i,
                         input int st, input int xx,
                         input int lv);
    chk($sformatf("%s[%0d].state", tag, i),
        32'(fsm_state), st);
    chk($sformatf("%s[%0d].x", tag, i), 32'(x), xx);
    chk($sformatf("%s[%0d].lvl", tag, i),
        32'(btn_level), lv);
  endtask

  initial begin
    // Reset held with button pressed: nothing may move.
    btn_in = 1'b1;
    repeat (3) tick();
    chk_out("rst_hold", 0, 0, 0, 0);
    btn_in = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk_out("rst_rel", 0, 0, 0, 0);

    // Clean press: x high only after edge k+6.
    p0 = npulse;
    btn_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("press", i, cp_st[i], cp_x[i],
              int'(cp_st[i] >= 2));
    end
    repeat (12) tick();
    chk_out("hold20", 0, 2, 0, 1);
    chk("press.pulses", 32'(npulse - p0), 1);

    // Clean release: level drops 6 edges after first 0.
    btn_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out("release", i, rl_st[i], 0,
              int'(rl_st[i] >= 2));
    end
    repeat (3) tick();

    // Glitch of two cycles: 00 -> 01 -> 00, no output.
    p0 = npulse;
    btn_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) btn_in = 1'b0;
      chk_out("glitch", i, gl_st[i], 0, 0);
    end
    repeat (4) tick();
    chk("glitch.pulses", 32'(npulse - p0), 0);

    // Release bounce: no second pulse.
    btn_in = 1'b1;
    repeat (10) tick();
    chk_out("rb_pre", 0, 2, 0, 1);
    p0 = npulse;
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) btn_in = 1'b1;
      if (i == 4) btn_in = 1'b0;
      chk_out("bounce", i, rb_st[i], 0,
              int'(rb_st[i] >= 2));
    end
    chk("bounce.pulses", 32'(npulse - p0), 0);
    repeat (3) tick();

    // Four presses advance the model counter 00..11..00.
    ctr = 2'b00;
    for (int n = 0; n < 4; n++) begin
      btn_in = 1'b1;
      repeat (20) tick();
      btn_in = 1'b0;
      repeat (12) tick();
      chk($sformatf("four[%0d].ctr", n), 32'(ctr), ctr_e[n]);
      chk($sformatf("four[%0d].state", n),
          32'(fsm_state), 0);
    end

    // Reset in the middle of the press debounce.
    p0 = npulse;
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid.pre_state", 32'(fsm_state), 1);
    rst = 1'b0;
    #1;
    chk_out("mid_async", 0, 0, 0, 0);
    repeat (2) tick();
    chk_out("mid_held", 0, 0, 0, 0);
    chk("mid.nopulse", 32'(npulse - p0), 0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("mid_post", i, cp_st[i], cp_x[i],
              int'(cp_st[i] >= 2));
    end
    chk("mid.pulses", 32'(npulse - p0), 1);
    btn_in = 1'b0;
    repeat (12) tick();

    // Long hold: one pulse, level tracks the release.
    p0 = npulse;
    btn_in = 1'b1;
    repeat (100) tick();
    chk("long.pulses", 32'(npulse - p0), 1);
    chk("long.lvl", 32'(btn_level), 1);
    btn_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("long_rel[%0d].lvl", i),
          32'(btn_level), int'(i < 6));
    end
    chk("long.end_state", 32'(fsm_state), 0);
    chk("long.pulses_end", 32'(npulse - p0), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
